// File: rtl/countdown_display_driver.sv
// Four-digit common-anode display driver for the countdown timer: shows the remaining
// seconds with the leading zero blanked and flashes "8.8.8.8." once the bomb has blown.
module countdown_display_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] Counter_Out,
  input  logic       Blow_Up,
  output logic [6:0] Seg,
  output logic [3:0] An,
  output logic       Dp
);

  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 4;

  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b111_1111;
  localparam logic [SEG_W-1:0] SEG_ALL   = 7'b000_0000;
  localparam logic [AN_W-1:0]  AN_OFF    = 4'b1111;
  localparam logic [AN_W-1:0]  AN_SLOT0  = 4'b1110;
  localparam logic [AN_W-1:0]  AN_SLOT1  = 4'b1101;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             boom_q, boom_d;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [SEL_W-1:0] digit_sel_q, digit_sel_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [AN_W-1:0]  an_q, an_d;
  logic             dp_q, dp_d;

  logic [1:0]       tens_c;
  logic [3:0]       units_c;
  logic             ref_wrap_c;
  logic             blk_wrap_c;

  // Segment pattern {g,f,e,d,c,b,a}, active-low
  function automatic logic [SEG_W-1:0] seg_code(input logic [3:0] digit);
    logic [SEG_W-1:0] code;
    case (digit)
      4'd0:    code = 7'b100_0000;
      4'd1:    code = 7'b111_1001;
      4'd2:    code = 7'b010_0100;
      4'd3:    code = 7'b011_0000;
      4'd4:    code = 7'b001_1001;
      4'd5:    code = 7'b001_0010;
      4'd6:    code = 7'b000_0010;
      4'd7:    code = 7'b111_1000;
      4'd8:    code = 7'b000_0000;
      4'd9:    code = 7'b001_0000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Input capture: nothing downstream looks at the raw ports
  always_comb begin
    cnt_d  = Counter_Out;
    boom_d = Blow_Up;
  end

  // Binary-to-BCD for 0..31 by range compare; avoids a divider
  always_comb begin
    tens_c  = 2'd0;
    units_c = 4'(cnt_q);
    if (cnt_q >= 5'd30) begin
      tens_c  = 2'd3;
      units_c = 4'(cnt_q - 5'd30);
    end else if (cnt_q >= 5'd20) begin
      tens_c  = 2'd2;
      units_c = 4'(cnt_q - 5'd20);
    end else if (cnt_q >= 5'd10) begin
      tens_c  = 2'd1;
      units_c = 4'(cnt_q - 5'd10);
    end
  end

  // Digit scan keeps running regardless of detonation state
  always_comb begin
    ref_wrap_c  = (ref_cnt_q == REF_LAST);
    ref_cnt_d   = ref_wrap_c ? '0 : ref_cnt_q + REF_W'(1);
    digit_sel_d = ref_wrap_c ? digit_sel_q + SEL_W'(1) : digit_sel_q;
  end

  // Blink timer parks in the visible phase whenever the bomb is not blown
  always_comb begin
    blk_wrap_c = (blk_cnt_q == BLK_LAST);
    blk_cnt_d  = '0;
    blink_on_d = 1'b1;
    if (boom_q) begin
      blk_cnt_d  = blk_wrap_c ? '0 : blk_cnt_q + BLK_W'(1);
      blink_on_d = blk_wrap_c ? ~blink_on_q : blink_on_q;
    end
  end

  // Next display word for the currently selected slot
  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = AN_OFF;
    dp_d  = 1'b1;
    if (boom_q) begin
      if (blink_on_q) begin
        an_d  = ~(AN_W'(1) << digit_sel_q);
        seg_d = SEG_ALL;
        dp_d  = 1'b0;
      end
    end else begin
      case (digit_sel_q)
        2'd0: begin
          an_d  = AN_SLOT0;
          seg_d = seg_code(units_c);
        end
        2'd1: begin
          if (tens_c != 2'd0) begin
            an_d  = AN_SLOT1;
            seg_d = seg_code({2'b00, tens_c});
          end
        end
        default: begin
          an_d  = AN_OFF;
          seg_d = SEG_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q       <= '0;
      boom_q      <= 1'b0;
      ref_cnt_q   <= '0;
      digit_sel_q <= '0;
      blk_cnt_q   <= '0;
      blink_on_q  <= 1'b1;
      seg_q       <= SEG_BLANK;
      an_q        <= AN_OFF;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      boom_q      <= boom_d;
      ref_cnt_q   <= ref_cnt_d;
      digit_sel_q <= digit_sel_d;
      blk_cnt_q   <= blk_cnt_d;
      blink_on_q  <= blink_on_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      dp_q        <= dp_d;
    end
  end

  assign Seg = seg_q;
  assign An  = an_q;
  assign Dp  = dp_q;

endmodule

// File: tb/tb_countdown_display_driver.sv
// Scoreboard bench for countdown_display_driver: stimulus queues the expected display word
// for each future clock edge, a monitor compares the outputs just after every edge.
`timescale 1ns/1ps
module tb_countdown_display_driver;

  localparam int unsigned RD = 4;
  localparam int unsigned BD = 16;
  localparam logic [11:0] OFF = 12'hFFF;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [4:0] Counter_Out;
  logic       Blow_Up;
  logic [6:0] Seg;
  logic [3:0] An;
  logic       Dp;

  countdown_display_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .Clock(Clock), .Reset(Reset), .Counter_Out(Counter_Out), .Blow_Up(Blow_Up),
    .Seg(Seg), .An(An), .Dp(Dp)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          cyc;
    int          tag;
    logic [11:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   rel = 0;
  int   vis0 = 0;
  bit   prev_boom = 1'b0;

  // Hand-entered digit codes {g,f,e,d,c,b,a}
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input int tag, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL chk%0d cyc=%0d got An=%b Seg=%b Dp=%b want An=%b Seg=%b Dp=%b",
               tag, cyc, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // Slot whose content is presented at output edge e, given the last reset release
  function automatic int slot_at(input int e);
    return ((e - rel - 1) / RD) % 4;
  endfunction

  function automatic logic [11:0] exp_num(input int v, input int slot);
    int t = v / 10;
    int u = v % 10;
    case (slot)
      0:       return {4'b1110, seg_tab[u], 1'b1};
      1:       return (t == 0) ? OFF : {4'b1101, seg_tab[t], 1'b1};
      default: return OFF;
    endcase
  endfunction

  function automatic logic [11:0] exp_boom(input int e);
    logic [3:0] a;
    int idx = (e - vis0) / BD;
    a = 4'b0001 << slot_at(e);
    a = ~a;
    return (idx % 2 == 0) ? {a, 7'b0000000, 1'b0} : OFF;
  endfunction

  task automatic push(input int e, input int tag, input logic [11:0] x);
    exp_t t;
    t.cyc = e;
    t.tag = tag;
    t.exp = x;
    sb.push_back(t);
  endtask

  // Called at a falling edge; checks edges k+2 .. k+1+len, returns at the falling edge after the last
  task automatic apply(input int v, input bit b, input int len, input int tag);
    int k = cyc;
    if (b && !prev_boom) vis0 = k + 2;
    prev_boom   = b;
    Counter_Out = 5'(v);
    Blow_Up     = b;
    for (int e = k + 2; e <= k + 1 + len; e++)
      push(e, tag, b ? exp_boom(e) : exp_num(v, slot_at(e)));
    repeat (len + 1) @(negedge Clock);
  endtask

  always @(posedge Clock) begin
    #1;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t t;
      t = sb.pop_front();
      if (t.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL chk%0d missed edge %0d (now %0d)", t.tag, t.cyc, cyc);
      end else begin
        check(t.tag, {An, Seg, Dp}, t.exp);
      end
    end
  end

  initial begin
    Reset       = 1'b1;
    Counter_Out = 5'd15;
    Blow_Up     = 1'b0;
    #3 Reset = 1'b0;
    #1 check(0, {An, Seg, Dp}, OFF);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    rel   = cyc;
    push(rel + 1, 1, exp_num(0, 0));
    apply(15, 1'b0, 32, 2);
    apply(7, 1'b0, 16, 3);
    apply(0, 1'b0, 16, 4);
    apply(31, 1'b0, 16, 5);

    // Asynchronous reset in the middle of a slot
    #2;
    Counter_Out = 5'd15;
    Reset       = 1'b0;
    #1 check(6, {An, Seg, Dp}, OFF);
    for (int e = cyc + 1; e <= cyc + 3; e++) push(e, 6, OFF);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    rel   = cyc;
    push(rel + 1, 7, exp_num(0, 0));
    apply(15, 1'b0, 16, 8);
    apply(9, 1'b0, 16, 9);

    // Detonation, release during a blank phase, re-entry with a visible phase
    apply(5, 1'b1, 20, 10);
    apply(5, 1'b0, 16, 11);
    apply(12, 1'b1, 40, 12);
    apply(12, 1'b1, 40, 13);
    apply(12, 1'b0, 12, 14);

    // Countdown to zero, then detonation
    for (int v = 15; v >= 0; v--) apply(v, 1'b0, 39, 100 + v);
    apply(0, 1'b1, 40, 15);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clock);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
